// File: rtl/wb_arbiter_pkg.sv
// Shared CPU definitions used by the writeback arbiter and its scoreboard:
// requester index encoding, register address width and data width.
package wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_idx_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard, one busy bit per architectural register.
// Ports:
//   clk, rst_n              clock, async active-low reset (clears all bits)
//   set_en_i / set_addr_i   reserve a destination (address 0 is ignored)
//   clr_en_i / clr_addr_i   release a destination on writeback acceptance
//   rd_addr0_i / busy0_o    read port 0 (combinational, 0 for address 0)
//   rd_addr1_i / busy1_o    read port 1 (combinational, 0 for address 0)
module wb_scoreboard
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REG = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en_i,
  input  reg_addr_t set_addr_i,
  input  logic      clr_en_i,
  input  reg_addr_t clr_addr_i,
  input  reg_addr_t rd_addr0_i,
  input  reg_addr_t rd_addr1_i,
  output logic      busy0_o,
  output logic      busy1_o
);

  logic [NUM_REG-1:0] busy_q, busy_d;

  // Clear is applied first so a same-edge reservation of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i && (set_addr_i != '0)) busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy0_o = (rd_addr0_i != '0) && busy_q[rd_addr0_i];
  assign busy1_o = (rd_addr1_i != '0) && busy_q[rd_addr1_i];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load-unit writeback requests onto a single
// register-file write port (latency 1) and tracks pending destinations.
// Configuration macro WB_ARB_RR_EN: defined -> round-robin on ties,
// undefined -> fixed priority with MEM winning ties.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   alu_valid/ready/rd/data             ALU writeback handshake
//   mem_valid/ready/rd/data             load-unit writeback handshake
//   rf_we / rf_rd_addr / rf_wdata       registered register-file write port
//   alloc_valid / alloc_rd              destination reservation from issue
//   chk_rs1/2 -> busy_rs1/2             pending-write lookup for sources
//
// Arbitration state (round-robin build only):
//   state   | meaning
//   REQ_ALU | ALU served most recently, MEM wins the next tie (reset value)
//   REQ_MEM | MEM served most recently, ALU wins the next tie
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REG = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      alu_valid,
  output logic      alu_ready,
  input  reg_addr_t alu_rd,
  input  data_t     alu_data,
  input  logic      mem_valid,
  output logic      mem_ready,
  input  reg_addr_t mem_rd,
  input  data_t     mem_data,
  output logic      rf_we,
  output reg_addr_t rf_rd_addr,
  output data_t     rf_wdata,
  input  logic      alloc_valid,
  input  reg_addr_t alloc_rd,
  input  reg_addr_t chk_rs1,
  input  reg_addr_t chk_rs2,
  output logic      busy_rs1,
  output logic      busy_rs2
);

  logic      grant_alu, grant_mem, accept;
  reg_addr_t acc_rd;
  data_t     acc_data;

`ifdef WB_ARB_RR_EN
  req_idx_e last_q;

  always_comb begin
    grant_mem = mem_valid && (!alu_valid || (last_q == REQ_ALU));
    grant_alu = alu_valid && !grant_mem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_q <= REQ_ALU;
    else if (grant_mem) last_q <= REQ_MEM;
    else if (grant_alu) last_q <= REQ_ALU;
  end
`else
  always_comb begin
    grant_mem = mem_valid;
    grant_alu = alu_valid && !mem_valid;
  end
`endif

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;
  assign accept    = grant_alu || grant_mem;
  assign acc_rd    = grant_mem ? mem_rd   : alu_rd;
  assign acc_data  = grant_mem ? mem_data : alu_data;

  logic      rf_we_q, rf_we_d;
  reg_addr_t rf_rd_addr_q, rf_rd_addr_d;
  data_t     rf_wdata_q, rf_wdata_d;

  // Writes to x0 are still accepted (and release nothing useful) but never strobe.
  always_comb begin
    rf_we_d      = 1'b0;
    rf_rd_addr_d = rf_rd_addr_q;
    rf_wdata_d   = rf_wdata_q;
    if (accept) begin
      rf_we_d      = (acc_rd != '0);
      rf_rd_addr_d = acc_rd;
      rf_wdata_d   = acc_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q      <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_wdata_q   <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign rf_wdata   = rf_wdata_q;

  wb_scoreboard #(.NUM_REG(NUM_REG)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (alloc_valid),
    .set_addr_i (alloc_rd),
    .clr_en_i   (accept),
    .clr_addr_i (acc_rd),
    .rd_addr0_i (chk_rs1),
    .rd_addr1_i (chk_rs2),
    .busy0_o    (busy_rs1),
    .busy1_o    (busy_rs2)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, rf_rd_addr, alloc_rd, chk_rs1, chk_rs2;
  logic [31:0] alu_data, mem_data, rf_wdata;
  logic        rf_we, alloc_valid, busy_rs1, busy_rs2;

  int tests = 0;
  int fails = 0;

  // Reference model state: which registers have a pending write, who was
  // served last (0 = ALU, 1 = MEM).
  bit [31:0] busy_m;
  int        last_m;

  wb_arbiter #(.NUM_REG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_wdata(rf_wdata),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", name, obs, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // -1 none, 0 ALU, 1 MEM
  function automatic int model_grant();
    if (alu_valid && mem_valid) begin
`ifdef WB_ARB_RR_EN
      return (last_m == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    if (alu_valid) return 0;
    if (mem_valid) return 1;
    return -1;
  endfunction

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alloc_valid = 1'b0; alloc_rd = '0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    int          g;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    #1;
    g      = model_grant();
    e_rd   = (g == 1) ? mem_rd : alu_rd;
    e_data = (g == 1) ? mem_data : alu_data;
    chk1("alu_ready", alu_ready, g == 0);
    chk1("mem_ready", mem_ready, g == 1);
    chk1("busy_rs1", busy_rs1, (chk_rs1 != 0) && busy_m[chk_rs1]);
    chk1("busy_rs2", busy_rs2, (chk_rs2 != 0) && busy_m[chk_rs2]);
    @(posedge clk);
    if (g >= 0) begin
      busy_m[e_rd] = 1'b0;
      last_m = g;
    end
    if (alloc_valid && alloc_rd != 0) busy_m[alloc_rd] = 1'b1;
    #1;
    chk1("rf_we", rf_we, (g >= 0) && (e_rd != 0));
    if (g >= 0) begin
      chk32("rf_rd_addr", {27'b0, rf_rd_addr}, {27'b0, e_rd});
      chk32("rf_wdata", rf_wdata, e_data);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    chk_rs1 = 5'd5; chk_rs2 = 5'd0;
    busy_m = '0; last_m = 0;
    @(negedge clk); @(negedge clk);
    chk1("rst_rf_we", rf_we, 1'b0);
    chk32("rst_rf_addr", {27'b0, rf_rd_addr}, 32'd0);
    chk32("rst_rf_wdata", rf_wdata, 32'd0);
    chk1("rst_busy", busy_rs1, 1'b0);
    rst_n = 1'b1;

    // Tie for four cycles straight after reset.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1_0001;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB2B2_0002;
    repeat (4) step();
    idle();

    // Lone ALU write.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    step();
    idle();
    step();

    // Write to x0 is accepted but never strobes.
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF_FFFF;
    step();
    idle();

    // Reserve, observe busy, release via ALU writeback.
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    step();
    idle(); chk_rs1 = 5'd7; chk_rs2 = 5'd7;
    step();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_0007;
    step();
    idle();
    step();

    // Same-edge reserve and release of one register: reservation survives.
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    step();
    alloc_rd = 5'd9; mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9999_0009;
    chk_rs1 = 5'd9;
    step();
    idle();
    step();

    // Randomized traffic with small register range to force collisions.
    for (int i = 0; i < 300; i++) begin
      alu_valid   = 1'($urandom_range(0, 1));
      alu_rd      = 5'($urandom_range(0, 12));
      alu_data    = $urandom();
      mem_valid   = 1'($urandom_range(0, 1));
      mem_rd      = 5'($urandom_range(0, 12));
      mem_data    = $urandom();
      alloc_valid = ($urandom_range(0, 2) != 0);
      alloc_rd    = 5'($urandom_range(0, 12));
      chk_rs1     = 5'($urandom_range(0, 12));
      chk_rs2     = 5'($urandom_range(0, 31));
      step();
    end
    idle();

    // Reset mid-operation: accepted write is dropped, scoreboard wiped.
    alloc_valid = 1'b1; alloc_rd = 5'd11;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_0003;
    step();
    idle();
    rst_n = 1'b0;
    #1;
    chk1("midrst_rf_we", rf_we, 1'b0);
    chk32("midrst_rf_addr", {27'b0, rf_rd_addr}, 32'd0);
    chk32("midrst_rf_wdata", rf_wdata, 32'd0);
    for (int r = 1; r < 32; r++) begin
      chk_rs1 = 5'(r);
      #1;
      chk1("midrst_busy", busy_rs1, 1'b0);
    end
    busy_m = '0; last_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_rs1 = 5'd11; chk_rs2 = 5'd3;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
